// File: rtl/i2s_frontend.sv
// i2s_frontend: I2S ADC left-word deserialiser and DAC serialiser, oversampled in the clk domain
// Ports: clk/reset (sync, active-high); bclk, lrclk, sdin raw I2S pins; sdout DAC data;
//        in_sample/sample_valid received left word; out_sample/engine_ready engine result;
//        overrun/overrun_count missed-ready flags; short_slot truncated left slot; locked framing seen
module i2s_frontend #(
   parameter int data_width = 16,
   parameter int slot_width = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  bclk,
   input  logic                  lrclk,
   input  logic                  sdin,
   output logic                  sdout,
   output logic [data_width-1:0] in_sample,
   output logic                  sample_valid,
   input  logic [data_width-1:0] out_sample,
   input  logic                  engine_ready,
   output logic                  overrun,
   output logic [7:0]            overrun_count,
   output logic                  short_slot,
   output logic                  locked
);
   localparam logic [5:0] dw_idx = 6'(data_width);
   logic [2:0] bclk_p;
   logic [1:0] lr_p, sd_p;
   logic rise, fall, lr, sd, rx_edge, in_left, take, cap, short_hit;
   logic lr_prev_rx, lr_prev_tx, primed, ready_d;
   logic [5:0] rx_idx, rx_idx_n;
   logic [data_width-1:0] rx_shift, tx_hold;
   logic [slot_width-1:0] tx_shift;
   // primed: the first rise after reset only records lrclk, so a partial slot is never mistaken for framing
   always_comb begin
      rise = bclk_p[1] & ~bclk_p[2];
      fall = ~bclk_p[1] & bclk_p[2];
      lr = lr_p[1];
      sd = sd_p[1];
      rx_edge = lr != lr_prev_rx;
      rx_idx_n = rx_edge ? 6'd0 : (rx_idx == 6'd63 ? rx_idx : rx_idx + 6'd1);
      in_left = rise & primed & ~lr & ~rx_edge;
      take = in_left & (rx_idx_n >= 6'd1) & (rx_idx_n <= dw_idx);
      cap = in_left & (rx_idx_n == dw_idx) & locked;
      short_hit = rise & primed & rx_edge & lr & locked & (rx_idx < dw_idx);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         bclk_p <= '0;
         lr_p <= '0;
         sd_p <= '0;
         sdout <= 1'b0;
         in_sample <= '0;
         sample_valid <= 1'b0;
         overrun <= 1'b0;
         overrun_count <= '0;
         short_slot <= 1'b0;
         locked <= 1'b0;
         lr_prev_rx <= 1'b1;
         lr_prev_tx <= 1'b1;
         primed <= 1'b0;
         ready_d <= 1'b1;
         rx_idx <= 6'd63;
         rx_shift <= '0;
         tx_hold <= '0;
         tx_shift <= '0;
      end else begin
         bclk_p <= {bclk_p[1:0], bclk};
         lr_p <= {lr_p[0], lrclk};
         sd_p <= {sd_p[0], sdin};
         sample_valid <= cap;
         overrun <= cap & ~engine_ready;
         short_slot <= short_hit;
         if (cap) in_sample <= {rx_shift[data_width-2:0], sd};
         if (cap & ~engine_ready & (overrun_count != 8'hff)) overrun_count <= overrun_count + 8'd1;
         if (take) rx_shift <= {rx_shift[data_width-2:0], sd};
         if (rise) begin
            lr_prev_rx <= lr;
            primed <= 1'b1;
            rx_idx <= primed ? rx_idx_n : 6'd63;
            if (primed & rx_edge) locked <= 1'b1;
         end
         ready_d <= engine_ready;
         if (engine_ready & ~ready_d) tx_hold <= out_sample;
         if (fall) begin
            lr_prev_tx <= lr;
            if (lr != lr_prev_tx) begin
               tx_shift <= {tx_hold, {(slot_width - data_width){1'b0}}};
               sdout <= 1'b0;
            end else begin
               sdout <= tx_shift[slot_width-1];
               tx_shift <= tx_shift << 1;
            end
         end
      end
   end
endmodule

// File: tb/tb_i2s_frontend.sv
// tb_i2s_frontend: directed I2S frames with hand-computed receive/transmit expectations
module tb_i2s_frontend;
   logic clk = 1'b0;
   logic reset, bclk, lrclk, sdin, engine_ready;
   logic [15:0] out_sample;
   logic sdout, sample_valid, overrun, short_slot, locked;
   logic [15:0] in_sample;
   logic [7:0] overrun_count;
   int checks = 0, fails = 0;
   int sv_n = 0, ov_n = 0, ss_n = 0;
   int sv0, ov0, ss0;
   logic [15:0] last_in = '0;
   logic [15:0] txl, txr;
   logic tx_junk;

   i2s_frontend #(.data_width(16), .slot_width(32)) dut (
      .clk(clk), .reset(reset), .bclk(bclk), .lrclk(lrclk), .sdin(sdin), .sdout(sdout),
      .in_sample(in_sample), .sample_valid(sample_valid), .out_sample(out_sample),
      .engine_ready(engine_ready), .overrun(overrun), .overrun_count(overrun_count),
      .short_slot(short_slot), .locked(locked)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (sample_valid) begin
         sv_n++;
         last_in = in_sample;
      end
      if (overrun) ov_n++;
      if (short_slot) ss_n++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic snap();
      sv0 = sv_n;
      ov0 = ov_n;
      ss0 = ss_n;
   endtask

   task automatic frame(input logic [15:0] l, input logic [15:0] r, input int nl, input int nr,
                        input int half, input int rst_at);
      int j;
      logic [15:0] w;
      logic b;
      txl = '0;
      txr = '0;
      tx_junk = 1'b0;
      for (int k = 0; k < nl + nr; k++) begin
         j = (k < nl) ? k : k - nl;
         w = (k < nl) ? l : r;
         bclk = 1'b0;
         lrclk = (k >= nl);
         sdin = (j == 0) ? 1'b1 : ((j <= 16) ? w[16-j] : 1'b0);
         repeat (half) @(negedge clk);
         b = sdout;
         if (j >= 1 && j <= 16) begin
            if (k < nl) txl[16-j] = b;
            else txr[16-j] = b;
         end else tx_junk = tx_junk | b;
         bclk = 1'b1;
         if (k == rst_at) begin
            @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            chk("rst_mid_in", in_sample, 0);
            chk("rst_mid_cnt", overrun_count, 0);
            chk("rst_mid_locked", locked, 0);
            chk("rst_mid_sdout", sdout, 0);
            chk("rst_mid_valid", sample_valid, 0);
            repeat (half - 2) @(negedge clk);
         end else repeat (half) @(negedge clk);
      end
   endtask

   initial begin
      reset = 1'b1;
      bclk = 1'b0;
      lrclk = 1'b1;
      sdin = 1'b0;
      engine_ready = 1'b0;
      out_sample = '0;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_sdout", sdout, 0);
      chk("rst_in", in_sample, 0);
      chk("rst_valid", sample_valid, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_count", overrun_count, 0);
      chk("rst_short", short_slot, 0);
      chk("rst_locked", locked, 0);
      engine_ready = 1'b1;
      repeat (2) @(negedge clk);
      // lock frame: first slot after reset is never reported
      snap();
      frame(16'h1111, 16'h2222, 32, 32, 8, -1);
      chk("lock_locked", locked, 1);
      chk("lock_valid_n", sv_n - sv0, 0);
      chk("lock_short_n", ss_n - ss0, 0);
      // basic receive
      snap();
      frame(16'h8001, 16'h1234, 32, 32, 8, -1);
      chk("basic_valid_n", sv_n - sv0, 1);
      chk("basic_in", last_in, 16'h8001);
      chk("basic_ovr_n", ov_n - ov0, 0);
      chk("basic_tx_silent", {txl, txr}, 0);
      // transmit
      engine_ready = 1'b0;
      out_sample = 16'hA5C3;
      repeat (3) @(negedge clk);
      engine_ready = 1'b1;
      repeat (3) @(negedge clk);
      out_sample = 16'hFFFF;
      snap();
      frame(16'h7FFF, 16'h0001, 32, 32, 8, -1);
      chk("tx_left", txl, 16'hA5C3);
      chk("tx_right", txr, 16'hA5C3);
      chk("tx_pad", tx_junk, 0);
      chk("tx_rx_in", last_in, 16'h7FFF);
      chk("tx_ovr_n", ov_n - ov0, 0);
      // stalled engine
      engine_ready = 1'b0;
      out_sample = 16'h1234;
      snap();
      frame(16'h1111, 16'h0000, 32, 32, 8, -1);
      frame(16'h2222, 16'h0000, 32, 32, 8, -1);
      frame(16'h3333, 16'h0000, 32, 32, 8, -1);
      chk("stall_ovr_n", ov_n - ov0, 3);
      chk("stall_count", overrun_count, 3);
      chk("stall_valid_n", sv_n - sv0, 3);
      chk("stall_in", last_in, 16'h3333);
      chk("stall_tx_repeat", {txl, txr}, {16'hA5C3, 16'hA5C3});
      engine_ready = 1'b1;
      repeat (3) @(negedge clk);
      // short slot
      snap();
      frame(16'hBEEF, 16'h5555, 10, 32, 8, -1);
      chk("short_n", ss_n - ss0, 1);
      chk("short_valid_n", sv_n - sv0, 0);
      snap();
      frame(16'h4321, 16'h0000, 32, 32, 8, -1);
      chk("post_short_valid_n", sv_n - sv0, 1);
      chk("post_short_in", last_in, 16'h4321);
      chk("post_short_tx", txl, 16'h1234);
      chk("post_short_short_n", ss_n - ss0, 0);
      // reset mid-frame at left bit 7
      snap();
      frame(16'hCAFE, 16'h0000, 32, 32, 8, 7);
      chk("rst_frame_valid_n", sv_n - sv0, 0);
      chk("rst_frame_short_n", ss_n - ss0, 0);
      chk("rst_relock", locked, 1);
      snap();
      frame(16'h0F0F, 16'h0000, 32, 32, 8, -1);
      chk("rst_after_valid_n", sv_n - sv0, 1);
      chk("rst_after_in", last_in, 16'h0F0F);
      // saturation with fast, short frames
      engine_ready = 1'b0;
      snap();
      for (int n = 0; n < 300; n++) frame(16'h5A5A, 16'h0000, 17, 1, 4, -1);
      chk("sat_count", overrun_count, 255);
      chk("sat_ovr_n", ov_n - ov0, 300);
      chk("sat_valid_n", sv_n - sv0, 300);
      chk("sat_in", last_in, 16'h5A5A);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
